// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
// Parametrised maximal-length Fibonacci LFSR (WIDTH 3..16) used as a
// pseudo-random source and test-pattern generator. The register shifts left
// and inserts the XOR of its tapped bits at bit 0. A runtime seed can be
// loaded; a zero seed is replaced by SEED and flagged. A step counter tracks
// steps since the last reset or load, and a registered tick marks the state
// returning to the active seed.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous reset, active low
//   en        in   1      advance one step this cycle
//   load      in   1      load seed_in this cycle (priority over en)
//   seed_in   in   WIDTH  runtime seed value
//   lfsr_out  out  WIDTH  current LFSR state
//   max_tick  out  1      one-cycle pulse when the state is back at the seed
//   step_cnt  out  WIDTH  steps since last reset or load, wraps at 2^WIDTH-1
//   load_err  out  1      one-cycle pulse when a zero seed was rejected
// -----------------------------------------------------------------------------
module lfsr_gen #(
    parameter int WIDTH = 12,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             max_tick,
    output logic [WIDTH-1:0] step_cnt,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    // Last count value before wrapping: one period is 2^WIDTH-1 steps,
    // so the counter runs 0 .. 2^WIDTH-2.
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((1 << WIDTH) - 2);

    // Parameter legality is checked at elaboration.
    if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 3..16");
    end
    if (SEED <= 0 || SEED >= (1 << WIDTH)) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero and fit in WIDTH bits");
    end

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_cnt;
    logic             r_tick;
    logic             r_err;

    logic             w_fb;
    logic [WIDTH-1:0] w_next;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_cnt_inc;

    // Feedback taps for a maximal-length sequence. Tap k is bit q[k-1].
    case (WIDTH)
        3:  begin : g_t3  assign w_fb = r_q[2]  ^ r_q[1];                     end
        4:  begin : g_t4  assign w_fb = r_q[3]  ^ r_q[2];                     end
        5:  begin : g_t5  assign w_fb = r_q[4]  ^ r_q[2];                     end
        6:  begin : g_t6  assign w_fb = r_q[5]  ^ r_q[4];                     end
        7:  begin : g_t7  assign w_fb = r_q[6]  ^ r_q[5];                     end
        8:  begin : g_t8  assign w_fb = r_q[7]  ^ r_q[5]  ^ r_q[4] ^ r_q[3];  end
        9:  begin : g_t9  assign w_fb = r_q[8]  ^ r_q[4];                     end
        10: begin : g_t10 assign w_fb = r_q[9]  ^ r_q[6];                     end
        11: begin : g_t11 assign w_fb = r_q[10] ^ r_q[8];                     end
        12: begin : g_t12 assign w_fb = r_q[11] ^ r_q[5]  ^ r_q[3] ^ r_q[0];  end
        13: begin : g_t13 assign w_fb = r_q[12] ^ r_q[3]  ^ r_q[2] ^ r_q[0];  end
        14: begin : g_t14 assign w_fb = r_q[13] ^ r_q[4]  ^ r_q[2] ^ r_q[0];  end
        15: begin : g_t15 assign w_fb = r_q[14] ^ r_q[13];                    end
        16: begin : g_t16 assign w_fb = r_q[15] ^ r_q[14] ^ r_q[12] ^ r_q[3]; end
        default: begin : g_tdef assign w_fb = 1'b0; end
    endcase

    always_comb begin
        w_next      = {r_q[WIDTH-2:0], w_fb};
        w_seed_zero = (seed_in == '0);
        // A zero seed would lock the register at zero; fall back to SEED.
        w_load_val  = w_seed_zero ? SEED_W : seed_in;
        w_cnt_inc   = (r_cnt == CNT_LAST) ? '0 : (r_cnt + ONE_W);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= SEED_W;
            r_seed <= SEED_W;
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_err  <= 1'b0;
        end else if (load) begin
            r_q    <= w_load_val;
            r_seed <= w_load_val;
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_err  <= w_seed_zero;
        end else if (en) begin
            r_q    <= w_next;
            r_cnt  <= w_cnt_inc;
            // Tick lands on the same cycle lfsr_out shows the seed again;
            // the counter wraps to zero on that same step.
            r_tick <= (w_next == r_seed);
            r_err  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_err  <= 1'b0;
        end
    end

    assign lfsr_out = r_q;
    assign max_tick = r_tick;
    assign step_cnt = r_cnt;
    assign load_err = r_err;

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       en4, ld4, tick4, err4;
    logic [3:0] sd4, out4, cnt4;
    logic       en8, ld8, tick8, err8;
    logic [7:0] sd8, out8, cnt8;
    logic        en12, ld12, tick12, err12;
    logic [11:0] sd12, out12, cnt12;

    lfsr_gen #(.WIDTH(4), .SEED(1)) u_dut4 (
        .clk(clk), .reset(rst_n), .en(en4), .load(ld4), .seed_in(sd4),
        .lfsr_out(out4), .max_tick(tick4), .step_cnt(cnt4), .load_err(err4));

    lfsr_gen #(.WIDTH(8), .SEED(1)) u_dut8 (
        .clk(clk), .reset(rst_n), .en(en8), .load(ld8), .seed_in(sd8),
        .lfsr_out(out8), .max_tick(tick8), .step_cnt(cnt8), .load_err(err8));

    lfsr_gen #(.WIDTH(12), .SEED(1)) u_dut12 (
        .clk(clk), .reset(rst_n), .en(en12), .load(ld12), .seed_in(sd12),
        .lfsr_out(out12), .max_tick(tick12), .step_cnt(cnt12), .load_err(err12));

    int checks = 0;
    int errors = 0;

    // Tap masks from the tap table (tap k -> bit k-1).
    localparam int M4  = 'hC;    // 4,3
    localparam int M8  = 'hB8;   // 8,6,5,4
    localparam int M12 = 'h829;  // 12,6,4,1

    int exp4 [15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};

    typedef struct {
        int q;
        int seed;
        int cnt;
        bit tick;
        bit err;
    } mdl_t;

    mdl_t m4, m8, m12;

    function automatic mdl_t mdl_rst();
        mdl_t r;
        r.q = 1; r.seed = 1; r.cnt = 0; r.tick = 1'b0; r.err = 1'b0;
        return r;
    endfunction

    function automatic int lfsr_step(int q, int w, int mask);
        int fb;
        fb = $countones(q & mask) & 1;
        return ((q << 1) | fb) & ((1 << w) - 1);
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, int w, int mask, bit en, bit ld, int sd);
        mdl_t n;
        n = m;
        n.tick = 1'b0;
        n.err  = 1'b0;
        if (ld) begin
            if (sd == 0) begin
                n.q = 1; n.seed = 1; n.err = 1'b1;
            end else begin
                n.q = sd; n.seed = sd;
            end
            n.cnt = 0;
        end else if (en) begin
            n.q    = lfsr_step(m.q, w, mask);
            n.cnt  = (m.cnt + 1) % ((1 << w) - 1);
            n.tick = (n.q == m.seed);
        end
        return n;
    endfunction

    // Advance models with the inputs present before the edge, then clock.
    task automatic cycle();
        if (rst_n) begin
            m4  = mdl_next(m4,  4,  M4,  en4,  ld4,  int'(sd4));
            m8  = mdl_next(m8,  8,  M8,  en8,  ld8,  int'(sd8));
            m12 = mdl_next(m12, 12, M12, en12, ld12, int'(sd12));
        end else begin
            m4 = mdl_rst(); m8 = mdl_rst(); m12 = mdl_rst();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out4 !== 4'd1) begin errors++; $display("FAIL reset_out4: got %h want 1", out4); end
        checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL reset_cnt4: got %h want 0", cnt4); end
        checks++; if (tick4 !== 1'b0) begin errors++; $display("FAIL reset_tick4: got %b want 0", tick4); end
        checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL reset_err4: got %b want 0", err4); end
        checks++; if (out8 !== 8'd1 || cnt8 !== 8'd0) begin errors++; $display("FAIL reset_dut8: out %h cnt %h want 01 00", out8, cnt8); end
        checks++; if (out12 !== 12'd1 || cnt12 !== 12'd0) begin errors++; $display("FAIL reset_dut12: out %h cnt %h want 001 000", out12, cnt12); end
        #3 rst_n = 1'b1;
    endtask

    task automatic test_w4_sequence();
        en4 = 1'b1; ld4 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            checks++; if (out4 !== exp4[i][3:0]) begin errors++; $display("FAIL w4_seq out step %0d: got %h want %h", i, out4, exp4[i][3:0]); end
            checks++; if (tick4 !== 1'(i == 14)) begin errors++; $display("FAIL w4_seq tick step %0d: got %b want %b", i, tick4, (i == 14)); end
            checks++; if (cnt4 !== 4'((i + 1) % 15)) begin errors++; $display("FAIL w4_seq cnt step %0d: got %0d want %0d", i, cnt4, (i + 1) % 15); end
        end
        en4 = 1'b0;
    endtask

    task automatic test_zero_seed();
        ld4 = 1'b1; sd4 = 4'd0;
        cycle();
        checks++; if (out4 !== 4'b0001) begin errors++; $display("FAIL zero_seed out: got %b want 0001", out4); end
        checks++; if (err4 !== 1'b1) begin errors++; $display("FAIL zero_seed err: got %b want 1", err4); end
        checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL zero_seed cnt: got %0d want 0", cnt4); end
        ld4 = 1'b0;
        cycle();
        checks++; if (err4 !== 1'b0 || out4 !== 4'b0001) begin errors++; $display("FAIL zero_seed pulse: err %b out %b want 0 0001", err4, out4); end
        ld4 = 1'b1; sd4 = 4'b1010;
        cycle();
        checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL load_1010 err: got %b want 0", err4); end
        checks++; if (out4 !== 4'b1010) begin errors++; $display("FAIL load_1010 out: got %b want 1010", out4); end
        ld4 = 1'b0; en4 = 1'b1;
        repeat (3) cycle();
        checks++; if (cnt4 !== 4'd3 || out4 !== m4.q[3:0]) begin errors++; $display("FAIL step_after_load: cnt %0d out %b want 3 %b", cnt4, out4, m4.q[3:0]); end
        ld4 = 1'b1; en4 = 1'b0; sd4 = 4'b1010;
        cycle();
        checks++; if (cnt4 !== 4'd0 || tick4 !== 1'b0 || out4 !== 4'b1010) begin errors++; $display("FAIL reload_same: cnt %0d tick %b out %b want 0 0 1010", cnt4, tick4, out4); end
        ld4 = 1'b0;
    endtask

    task automatic test_load_en_same();
        ld4 = 1'b1; en4 = 1'b1; sd4 = 4'b0110;
        cycle();
        checks++; if (out4 !== 4'b0110 || cnt4 !== 4'd0) begin errors++; $display("FAIL load_en out/cnt: %b %0d want 0110 0", out4, cnt4); end
        ld4 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            checks++; if (tick4 !== 1'(i == 14)) begin errors++; $display("FAIL load_en tick step %0d: got %b want %b", i, tick4, (i == 14)); end
            checks++; if (out4 !== m4.q[3:0] || cnt4 !== m4.cnt[3:0]) begin errors++; $display("FAIL load_en model step %0d: out %b cnt %0d want %b %0d", i, out4, cnt4, m4.q[3:0], m4.cnt); end
        end
        checks++; if (out4 !== 4'b0110) begin errors++; $display("FAIL load_en period end: got %b want 0110", out4); end
        en4 = 1'b0;
    endtask

    task automatic test_w8_random();
        int steps = 0;
        int dut_ticks = 0;
        int mdl_ticks = 0;
        logic [7:0] prev;
        ld8 = 1'b0;
        for (int i = 0; i < 1200 && errors < 40; i++) begin
            en8 = ($urandom_range(0, 99) < 55);
            prev = out8;
            cycle();
            if (en8) steps++;
            checks++; if (out8 !== m8.q[7:0] || cnt8 !== m8.cnt[7:0] || tick8 !== m8.tick || err8 !== 1'b0) begin
                errors++; $display("FAIL w8_rand cyc %0d: out %h cnt %0d tick %b err %b want %h %0d %b 0", i, out8, cnt8, tick8, err8, m8.q[7:0], m8.cnt, m8.tick);
            end
            if (!en8) begin
                checks++; if (out8 !== prev) begin errors++; $display("FAIL w8_hold cyc %0d: got %h want %h", i, out8, prev); end
            end
            if (m8.tick) mdl_ticks++;
            if (tick8 === 1'b1) begin
                dut_ticks++;
                checks++; if (steps !== 255) begin errors++; $display("FAIL w8_tick_steps: got %0d want 255", steps); end
                steps = 0;
            end
        end
        checks++; if (dut_ticks !== mdl_ticks || mdl_ticks < 2) begin errors++; $display("FAIL w8_tick_count: got %0d want %0d (>=2)", dut_ticks, mdl_ticks); end
        // Random loads mixed in, including zero seeds.
        for (int i = 0; i < 400 && errors < 40; i++) begin
            en8 = ($urandom_range(0, 99) < 60);
            ld8 = ($urandom_range(0, 19) == 0);
            sd8 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            cycle();
            checks++; if (out8 !== m8.q[7:0] || cnt8 !== m8.cnt[7:0] || tick8 !== m8.tick || err8 !== m8.err) begin
                errors++; $display("FAIL w8_load cyc %0d: out %h cnt %0d tick %b err %b want %h %0d %b %b", i, out8, cnt8, tick8, err8, m8.q[7:0], m8.cnt, m8.tick, m8.err);
            end
        end
        en8 = 1'b0; ld8 = 1'b0;
    endtask

    task automatic test_w12_period();
        bit seen [4096];
        int since = 0;
        int distinct = 0;
        int ticks = 0;
        foreach (seen[j]) seen[j] = 1'b0;
        en12 = 1'b1; ld12 = 1'b0;
        for (int i = 0; i < 8190 && errors < 40; i++) begin
            cycle();
            since++;
            checks++; if (out12 !== m12.q[11:0] || tick12 !== m12.tick || cnt12 !== m12.cnt[11:0]) begin
                errors++; $display("FAIL w12_model cyc %0d: out %h tick %b cnt %0d want %h %b %0d", i, out12, tick12, cnt12, m12.q[11:0], m12.tick, m12.cnt);
            end
            checks++; if (out12 === 12'd0) begin errors++; $display("FAIL w12_zero cyc %0d: got 000 want nonzero", i); end
            checks++; if (seen[out12] === 1'b1) begin errors++; $display("FAIL w12_dup cyc %0d: state %h repeated within period", i, out12); end
            seen[out12] = 1'b1;
            distinct++;
            if (tick12 === 1'b1) begin
                ticks++;
                checks++; if (since !== 4095) begin errors++; $display("FAIL w12_spacing: got %0d want 4095", since); end
                checks++; if (distinct !== 4095) begin errors++; $display("FAIL w12_distinct: got %0d want 4095", distinct); end
                since = 0;
                distinct = 0;
                foreach (seen[j]) seen[j] = 1'b0;
            end
        end
        checks++; if (ticks !== 2) begin errors++; $display("FAIL w12_ticks: got %0d want 2", ticks); end
        en12 = 1'b0;
    endtask

    task automatic test_reset_async();
        en4 = 1'b1; ld4 = 1'b0; en8 = 1'b1; ld8 = 1'b0;
        repeat (5) cycle();
        checks++; if (out4 === 4'd1) begin errors++; $display("FAIL async_pre: got %h want not 1", out4); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (out4 !== 4'd1) begin errors++; $display("FAIL async_out4: got %h want 1", out4); end
        checks++; if (cnt4 !== 4'd0 || tick4 !== 1'b0 || err4 !== 1'b0) begin errors++; $display("FAIL async_ctl4: cnt %0d tick %b err %b want 0 0 0", cnt4, tick4, err4); end
        checks++; if (out8 !== 8'd1 || cnt8 !== 8'd0) begin errors++; $display("FAIL async_dut8: out %h cnt %0d want 01 0", out8, cnt8); end
        m4 = mdl_rst(); m8 = mdl_rst(); m12 = mdl_rst();
        cycle();
        checks++; if (out4 !== 4'd1 || cnt4 !== 4'd0) begin errors++; $display("FAIL async_held: out %h cnt %0d want 1 0", out4, cnt4); end
        #3 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cycle();
            checks++; if (out4 !== exp4[i][3:0]) begin errors++; $display("FAIL async_restart step %0d: got %h want %h", i, out4, exp4[i][3:0]); end
            checks++; if (out8 !== m8.q[7:0]) begin errors++; $display("FAIL async_restart8 step %0d: got %h want %h", i, out8, m8.q[7:0]); end
        end
        en4 = 1'b0; en8 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en4 = 1'b0; ld4 = 1'b0; sd4 = '0;
        en8 = 1'b0; ld8 = 1'b0; sd8 = '0;
        en12 = 1'b0; ld12 = 1'b0; sd12 = '0;
        m4 = mdl_rst(); m8 = mdl_rst(); m12 = mdl_rst();
        test_reset();
        test_w4_sequence();
        test_zero_seed();
        test_load_en_same();
        test_w8_random();
        test_w12_period();
        test_reset_async();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised maximal-length Fibonacci LFSR that generalises the team's fixed 12-bit LFSR. It supports any width from 3 to 16, a step enable, and a runtime seed load with zero-seed protection. It also provides a step counter and a registered end-of-period tick. It serves as the pseudo-random source and test-pattern generator for downstream datapath blocks and benches.

## Interface
- WIDTH, 12: register width. Legal values are 3..16; any other value is an elaboration error.
- SEED, 1: reset seed. Must be nonzero and fit in WIDTH bits.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  advance one step this cycle.
- load  in  1  load seed_in this cycle; has priority over en.
- seed_in  in  WIDTH  runtime seed value.
- lfsr_out  out  WIDTH  current LFSR state.
- max_tick  out  1  one-cycle pulse when the state returns to the active seed.
- step_cnt  out  WIDTH  steps taken since the last reset or load.
- load_err  out  1  one-cycle pulse when a zero seed was rejected.

## Operation
- Internal registers:
  - q[WIDTH-1:0]: the state, driven on lfsr_out.
  - seed_reg: the active seed.
  - step_cnt.
  - max_tick.
  - load_err.
- Step rule:
  - fb = XOR of the tapped bits of q.
  - next = {q[WIDTH-2:0], fb}.
  - Tap k denotes bit q[k-1].
- Tap table (1-indexed), fixed by generate on WIDTH:
  - 3: 3,2
  - 4: 4,3
  - 5: 5,3
  - 6: 6,5
  - 7: 7,6
  - 8: 8,6,5,4
  - 9: 9,5
  - 10: 10,7
  - 11: 11,9
  - 12: 12,6,4,1
  - 13: 13,4,3,1
  - 14: 14,5,3,1
  - 15: 15,14
  - 16: 16,15,13,4
- Period is 2^WIDTH-1. The all-zero state is never reachable.
- Priority each cycle: reset > load > en > hold.
- load with seed_in != 0:
  - q <= seed_in, seed_reg <= seed_in, step_cnt <= 0.
  - max_tick <= 0, load_err <= 0.
- load with seed_in == 0:
  - q <= SEED, seed_reg <= SEED, step_cnt <= 0.
  - load_err <= 1, max_tick <= 0.
- en without load:
  - q <= next.
  - step_cnt <= step_cnt+1, wrapping from 2^WIDTH-2 to 0.
  - max_tick <= (next == seed_reg).
  - load_err <= 0.
- Idle (neither load nor en): q, seed_reg and step_cnt hold; max_tick <= 0, load_err <= 0.
- Invariant: whenever max_tick is 1, step_cnt is 0 and lfsr_out equals seed_reg.

## Timing
- Reset values: lfsr_out = SEED, seed_reg = SEED, step_cnt = 0, max_tick = 0, load_err = 0.
- Asserting reset clears state immediately, without waiting for a clock edge, including mid-sequence.
- Deassertion of reset must be synchronised externally; the first step occurs at the first rising edge with en = 1 after release.
- Latency is one cycle: the effect of en or load appears on the outputs after the same rising edge.
- max_tick and load_err are registered single-cycle pulses.
  - max_tick is aligned with lfsr_out showing the seed again.
  - With continuous en, max_tick fires every 2^WIDTH-1 cycles.
- en gaps stretch the period in clock cycles but not in steps: max_tick still follows exactly 2^WIDTH-1 enabled steps.
- load mid-period restarts the period from the new seed; the pending tick is lost.
- load and en in the same cycle: load wins, and no step is taken that cycle.
- Loading a value equal to the current seed_reg still resets step_cnt and produces no max_tick.

## Test plan
- WIDTH=4, SEED=1, reset then en=1 continuously:
  - lfsr_out sequence is 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, 0001.
  - max_tick is high only with the 15th 0001, when step_cnt = 0.
- WIDTH=12, SEED=1, en=1 continuously:
  - max_tick pulses exactly every 4095 cycles.
  - All 4095 nonzero states appear once per period (scoreboard).
  - State 0 never appears.
- WIDTH=4, load=1 with seed_in=0:
  - Next cycle lfsr_out = 0001 and load_err = 1 for one cycle.
  - A following load with seed_in=1010 gives load_err = 0 and lfsr_out = 1010.
- WIDTH=4, load=1 and en=1 in the same cycle with seed_in=0110:
  - lfsr_out = 0110 and step_cnt = 0 (no step).
  - max_tick next fires after 15 enabled steps, when lfsr_out = 0110.
- WIDTH=8, random en duty cycle:
  - max_tick follows exactly 255 enabled steps.
  - State holds while en = 0.
  - step_cnt matches a reference counter.
- Reset asserted mid-sequence between clock edges:
  - Outputs immediately go to SEED, 0, 0, 0.
  - Sequence restarts from SEED after release.
